// File: rtl/char_link_pkg.sv
// Shared definitions for the character link: UART FSM encodings and frame bit levels.
package char_link_pkg;
  localparam int CHAR_W = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/char_uart_tx_if.sv
// Character valid/ready handshake between the character source and the UART stage.
interface char_uart_tx_if;
  import char_link_pkg::*;
  logic              in_valid;
  logic [CHAR_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/char_uart_tx_fifo.sv
// Small synchronous character FIFO with occupancy count; pointers wrap mod DEPTH.
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wdata,
  input  logic                     rd_en,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_wr, do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/char_uart_tx.sv
// Buffers characters from the generator and serializes each as an 8N1 frame, LSB first.
module char_uart_tx
  import char_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  char_uart_tx_if.slave               in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
  logic              push, pop, full, empty;
  logic [CHAR_W-1:0] fifo_rdata;

  assign in_if.in_ready = !full;
  assign push           = in_if.in_valid && !full;

  char_fifo #(.DEPTH(FIFO_DEPTH), .W(CHAR_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (push),
    .wdata (in_if.in_data),
    .rd_en (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    ovf_d     = ovf_q || (in_if.in_valid && full);
    unique case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tx_d    = START_BIT;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_TC) begin
          baud_d    = '0;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_TC) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_TC) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames stay contiguous.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = START_BIT;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_char_uart_tx.sv
// Cycle-level scoreboard for char_uart_tx: a queue of accepted characters plus a frame timer predict the line.
module tb_char_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FLEN  = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx, busy, overflow;
  logic [2:0] fifo_count;

  char_uart_tx_if bus ();

  char_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (bus.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: characters waiting, the frame on the line and its elapsed cycles (-1 = idle).
  byte unsigned mq[$];
  byte unsigned fch;
  int           ft;
  bit           movf;

  function automatic logic exp_tx();
    int b;
    if (ft < 0) return 1'b1;
    b = ft / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return fch[b-1];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_tx"}, 32'(tx), 32'(exp_tx()));
    chk({tag, "_busy"}, 32'(busy), 32'(ft >= 0));
    chk({tag, "_cnt"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk({tag, "_ovf"}, 32'(overflow), 32'(movf));
  endtask

  task automatic model_edge(bit v, byte unsigned d);
    bit full_pre;
    full_pre = (mq.size() == DEPTH);
    if (v && full_pre) movf = 1'b1;
    if (ft < 0 || ft == FLEN - 1) begin
      if (mq.size() > 0) begin
        fch = mq.pop_front();
        ft  = 0;
      end else begin
        ft = -1;
      end
    end else begin
      ft++;
    end
    if (v && !full_pre) mq.push_back(d);
  endtask

  task automatic step(bit v, byte unsigned d, string tag);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    mq.delete();
    ft   = -1;
    movf = 1'b0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(byte unsigned c, string tag);
    int g = 0;
    while (!bus.in_ready && g < 500) begin
      step(1'b0, 8'h00, tag);
      g++;
    end
    chk({tag, "_rdy_wait"}, 32'(bus.in_ready), 32'd1);
    step(1'b1, c, tag);
  endtask

  initial begin
    logic [9:0]   gexp;
    byte unsigned str [9];
    int           g;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    mq.delete();
    ft   = -1;
    movf = 1'b0;
    #12;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Single 'G': start, 1,1,1,0,0,0,1,0, stop, each bit CPB clocks.
    gexp = 10'b1_0100_0111_0;
    step(1'b1, 8'h47, "g_wr");
    for (int k = 1; k <= FLEN + 5; k++) begin
      step(1'b0, 8'h00, "g");
      if (k <= FLEN) chk("g_bit", 32'(tx), 32'(gexp[(k-1)/CPB]));
      if (k == FLEN + 1) chk("g_busy_end", 32'(busy), 32'd0);
    end

    // "Guatemala" under the handshake; frames must chain without gaps.
    str = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6d, 8'h61, 8'h6c, 8'h61};
    for (int i = 0; i < 9; i++) send(str[i], "guat");
    for (int k = 0; k < 9 * FLEN; k++) step(1'b0, 8'h00, "guat");
    chk("guat_ovf", 32'(overflow), 32'd0);

    // Ignore in_ready for 6 cycles: 5 accepted, overflow sticks.
    do_reset("rst_a");
    for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom), "flood");
    chk("flood_rdy", 32'(bus.in_ready), 32'd0);
    chk("flood_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 5 * FLEN; k++) step(1'b0, 8'h00, "flood");
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset 17 cycles into a frame with characters still queued.
    do_reset("rst_b");
    for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom), "mid");
    g = 0;
    while (ft != 17 && g < 200) begin
      step(1'b0, 8'h00, "mid");
      g++;
    end
    chk("mid_reach17", 32'(ft), 32'd17);
    do_reset("rst_mid");
    chk("rst_mid_tx", 32'(tx), 32'd1);
    step(1'b1, 8'($urandom), "after");
    for (int k = 0; k < FLEN + 4; k++) step(1'b0, 8'h00, "after");

    // Write on the same edge as a STOP->START pop at count 3.
    do_reset("rst_c");
    for (int k = 0; k < 4; k++) step(1'b1, 8'($urandom), "same");
    chk("same_cnt3", 32'(fifo_count), 32'd3);
    g = 0;
    while (ft != FLEN - 1 && g < 200) begin
      step(1'b0, 8'h00, "same");
      g++;
    end
    chk("same_reach_stop", 32'(ft), 32'(FLEN - 1));
    step(1'b1, 8'($urandom), "same_edge");
    chk("same_cnt_hold", 32'(fifo_count), 32'd3);
    for (int k = 0; k < 5 * FLEN; k++) step(1'b0, 8'h00, "same");

    // Random traffic, sometimes ignoring in_ready.
    do_reset("rst_d");
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(0, 9) < 2), 8'($urandom), "rand");
    for (int k = 0; k < 5 * FLEN; k++) step(1'b0, 8'h00, "drain");
    chk("drain_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
